// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative Booth multiplier with a valid/ready handshake on
// both sides. Operands are extended by two bits (sign or zero, by tc) so that
// one signed Booth datapath serves both the signed and the unsigned mode.
// Build option: define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH/2+1 steps)
// instead of radix-2 (WIDTH+1 steps). Results and handshake are the same.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one Booth step per clock
// DONE  | product held on p, out_valid high until out_ready
module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  // Accumulator carries one guard bit above the extended multiplicand so the
  // +/-2a partial product of the radix-4 build can never wrap.
  localparam int AW = WIDTH + 3;
`ifdef BOOTH_RADIX4_EN
  // Multiplier register must hold an even number of bits for triplet scanning.
  localparam int QW = WIDTH + 2;
  localparam int N  = WIDTH / 2 + 1;
`else
  localparam int QW = WIDTH + 1;
  localparam int N  = WIDTH + 1;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   acc, acc_nx, mcand, addend, sum;
  logic [QW-1:0]   q, q_nx;
  logic            qm1, qm1_nx;
  logic [CW-1:0]   cnt;
  logic            last_step;

  assign last_step = (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // One Booth step: select the partial product and shift {acc, q, q-1}
  always_comb begin
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q[1], q[0], qm1})
      3'b001, 3'b010: addend = mcand;
      3'b011:         addend = mcand << 1;
      3'b100:         addend = -(mcand << 1);
      3'b101, 3'b110: addend = -mcand;
      default:        addend = '0;
    endcase
    sum    = acc + addend;
    acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nx   = {sum[1:0], q[QW-1:2]};
    qm1_nx = q[1];
`else
    case ({q[0], qm1})
      2'b01:   addend = mcand;
      2'b10:   addend = -mcand;
      default: addend = '0;
    endcase
    sum    = acc + addend;
    acc_nx = {sum[AW-1], sum[AW-1:1]};
    q_nx   = {sum[0], q[QW-1:1]};
    qm1_nx = q[0];
`endif
  end

  // Datapath registers: operand capture, iteration, product hold
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      mcand <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= {{(AW-WIDTH){a[WIDTH-1] & tc}}, a};
            q     <= {{(QW-WIDTH){b[WIDTH-1] & tc}}, b};
            qm1   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          q   <= q_nx;
          qm1 <= qm1_nx;
          cnt <= cnt + 1'b1;
          // Extension bits above 2*WIDTH are dropped; the product always fits.
          if (last_step) p <= {acc_nx[2*WIDTH-QW-1:0], q_nx};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Parametrised sequential Booth multiplier for the audio datapath: it generalises the existing combinational 16-bit radix-2 Booth array into an iterative, clocked unit.
- Configurable operand width and per-transaction signed/unsigned mode.
- Valid/ready handshake on both sides.
- Optional radix-4 recoding that halves latency.

Sits between sample sources (signal generator, filter coefficient paths) and accumulators wherever a full-width product is needed without a large combinational array.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 4 and even.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a, b, tc present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- tc  in  1  1 = both operands two's complement, 0 = both unsigned
- out_valid  out  1  product p valid
- out_ready  in  1  consumer takes p
- p  out  2*WIDTH  product, signed when tc was 1, unsigned when tc was 0

## Operation
- The single clock is clk. Reset rst is synchronous and active-high.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b, tc; load accumulator 0; clear step counter; go to RUN.
- Operand extension: a and b are extended to WIDTH+2 bits, sign-extended when tc = 1 and zero-extended when tc = 0. Unsigned inputs are therefore handled by the same signed Booth datapath.
- RUN: one Booth step per cycle on the extended operands.
  - Radix-2:
    - Examine the multiplier pair (q0, q-1): 01 adds a, 10 subtracts a.
    - Arithmetic-shift {acc, q, q-1} right by 1.
    - N = WIDTH+1 steps.
  - Radix-4 (macro set):
    - Examine the triplet (q1, q0, q-1) and add 0, ±a or ±2a.
    - Arithmetic-shift right by 2.
    - N = WIDTH/2+1 steps.
- After the last step, p is loaded with the low 2*WIDTH bits of the product and the block goes to DONE.
- Width rule: the full product always fits in 2*WIDTH bits for both modes. Extra extension bits are discarded and there is no saturation.
- DONE:
  - out_valid = 1 and p is held stable.
  - On out_ready: go to IDLE on the next edge and clear out_valid.
  - in_ready = 0 in DONE (no overlap).
- in_ready is 0 in RUN and DONE. in_valid while busy is ignored and not queued.
- Operand inputs may change freely after acceptance; the latched copies are used.

## Timing
- Reset values: state IDLE, out_valid 0, p 0, in_ready 0 while rst = 1 and 1 on the first cycle after release. Internal accumulator and counter are cleared.
- Accept edge E0. Steps at edges E1..EN. out_valid rises at edge EN.
  - Radix-2 at WIDTH=16: N = 17.
  - Radix-4 at WIDTH=16: N = 9.
- Latency is fixed and independent of operand values and tc.
- With out_ready held at 1, the handshake completes on the first DONE cycle and in_ready returns one cycle later. Throughput is one product per N+2 cycles.
- Backpressure: out_valid and p stay constant for any number of cycles until out_ready.
- rst during RUN or DONE aborts the operation. Next cycle is IDLE with out_valid 0 and p 0. A later out_ready has no effect.
- rst and in_valid in the same cycle: reset wins and nothing is accepted.

## Configuration
- BOOTH_RADIX4_EN defined:
  - Radix-4 modified Booth recoding with a ±2a partial product.
  - N = WIDTH/2+1.
- BOOTH_RADIX4_EN undefined:
  - Radix-2 recoding.
  - N = WIDTH+1.
- Interface, reset values, handshake and results are identical in both builds; only latency differs.

## Test plan
- Signed basic: tc=1, a=-1 (0xFFFF), b=1 -> p=0xFFFFFFFF, out_valid exactly N cycles after accept (17 radix-2, 9 radix-4).
- Signed corner: tc=1, a=b=-32768 (0x8000) -> p=0x40000000. Also a=0x8000, b=0x7FFF -> p=0xC0008000.
- Unsigned corner: tc=0, a=b=0xFFFF -> p=0xFFFE0001. Also tc=0, a=0x8000, b=2 -> p=0x00010000.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> p stable and in_ready=0 throughout. Raising out_ready gives in_ready=1 the next cycle. in_valid pulsed during RUN is not accepted.
- Reset mid-operation: assert rst at step 5 of a=1234, b=-5678 -> next cycle out_valid=0, p=0, IDLE. A new op a=3, b=-7 then gives p=0xFFFFFFEB.
- Random regression: 10k random a, b, tc with random out_ready stalls, compared against a reference product. Run in both BOOTH_RADIX4_EN builds and at WIDTH=8 and WIDTH=24.
